// File: rtl/alu_arbiter_2req_if.sv
// Request/response/ALU bundle for the two-requester ALU arbiter.
// The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_arbiter_2req_if #(
  parameter int WIDTH = 32
);
  // requester 0 request channel
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  // requester 1 request channel
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  // response channels
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;
  // shared ALU
  logic [1:0]       alu_c;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_data,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data,
    input  rsp1_ready,
    output alu_c, alu_a, alu_b,
    input  alu_y
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_data,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data,
    output rsp1_ready,
    input  alu_c, alu_a, alu_b,
    output alu_y
  );
endinterface

// File: rtl/alu_arbiter_2req.sv
// Round-robin arbiter sharing one external combinational ALU between two
// requesters. One operation is in flight at a time: IDLE grants, EXEC
// presents registered operands to the ALU, RESP holds the captured result
// until the owning requester takes it.

// Protocol properties of the arbiter's handshakes.
module alu_arbiter_2req_chk (
  input logic clk,
  input logic rst,
  input logic idle,
  input logic req0_valid,
  input logic req0_ready,
  input logic req1_valid,
  input logic req1_ready,
  input logic rsp0_valid,
  input logic rsp1_valid
);
  a_one_ready : assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));
  a_ready0_valid : assert property (@(posedge clk) disable iff (rst)
    req0_ready |-> req0_valid);
  a_ready1_valid : assert property (@(posedge clk) disable iff (rst)
    req1_ready |-> req1_valid);
  a_ready_idle : assert property (@(posedge clk) disable iff (rst)
    (req0_ready || req1_ready) |-> idle);
  a_one_rsp : assert property (@(posedge clk) disable iff (rst)
    !(rsp0_valid && rsp1_valid));
  a_rsp_not_idle : assert property (@(posedge clk) disable iff (rst)
    (rsp0_valid || rsp1_valid) |-> !idle);
endmodule

module alu_arbiter_2req #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_arbiter_2req_if.slave    bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic               grant_s;
  logic               acc0_s;
  logic               acc1_s;
  logic               rsp_hs_s;

  logic [1:0]         alu_c_r;
  logic [WIDTH-1:0]   alu_a_r;
  logic [WIDTH-1:0]   alu_b_r;
  logic [WIDTH-1:0]   result_r;
  logic               owner_r;
  logic               last_grant_r;
  logic               rsp0_valid_r;
  logic               rsp1_valid_r;
  logic               busy_r;
  logic [CNT_W-1:0]   done_count_r;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Request acceptance: only in IDLE, only the granted and valid requester.
  always_comb begin
    acc0_s = 1'b0;
    acc1_s = 1'b0;
    if (state_r == IDLE) begin
      acc0_s = bus.req0_valid && !grant_s;
      acc1_s = bus.req1_valid &&  grant_s;
    end else begin
      acc0_s = 1'b0;
      acc1_s = 1'b0;
    end
  end

  assign bus.req0_ready = acc0_s;
  assign bus.req1_ready = acc1_s;

  // Response handshake: only the owner's valid is ever high, so its ready alone matters.
  always_comb begin
    rsp_hs_s = 1'b0;
    if (rsp0_valid_r && bus.rsp0_ready) begin
      rsp_hs_s = 1'b1;
    end else if (rsp1_valid_r && bus.rsp1_ready) begin
      rsp_hs_s = 1'b1;
    end else begin
      rsp_hs_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc0_s || acc1_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; busy is registered alongside so it tracks state != IDLE exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Operand capture on acceptance; ALU inputs hold their last values otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_c_r      <= 2'b00;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (acc0_s) begin
      alu_c_r      <= bus.req0_op;
      alu_a_r      <= bus.req0_a;
      alu_b_r      <= bus.req0_b;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b0;
    end else if (acc1_s) begin
      alu_c_r      <= bus.req1_op;
      alu_a_r      <= bus.req1_a;
      alu_b_r      <= bus.req1_b;
      owner_r      <= 1'b1;
      last_grant_r <= 1'b1;
    end else begin
      alu_c_r      <= alu_c_r;
      alu_a_r      <= alu_a_r;
      alu_b_r      <= alu_b_r;
      owner_r      <= owner_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Result capture at the end of EXEC, once the ALU has seen stable operands for a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= {WIDTH{1'b0}};
    end else if (state_r == EXEC) begin
      result_r <= bus.alu_y;
    end else begin
      result_r <= result_r;
    end
  end

  // Response valids: raised for the owner on entry to RESP, dropped on its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EXEC: begin
          rsp0_valid_r <= ~owner_r;
          rsp1_valid_r <=  owner_r;
        end
        RESP: begin
          if (rsp_hs_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
          end else begin
            rsp0_valid_r <= rsp0_valid_r;
            rsp1_valid_r <= rsp1_valid_r;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Completed-response counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count_r <= {CNT_W{1'b0}};
    end else if (rsp_hs_s) begin
      done_count_r <= done_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      done_count_r <= done_count_r;
    end
  end

  assign bus.alu_c      = alu_c_r;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.rsp0_valid = rsp0_valid_r;
  assign bus.rsp1_valid = rsp1_valid_r;
  // Non-owner data reads as zero so a stale result never leaks to the other client.
  assign bus.rsp0_data  = owner_r ? {WIDTH{1'b0}} : result_r;
  assign bus.rsp1_data  = owner_r ? result_r : {WIDTH{1'b0}};
  assign busy           = busy_r;
  assign done_count     = done_count_r;

  alu_arbiter_2req_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .idle       (state_r == IDLE),
    .req0_valid (bus.req0_valid),
    .req0_ready (bus.req0_ready),
    .req1_valid (bus.req1_valid),
    .req1_ready (bus.req1_ready),
    .rsp0_valid (bus.rsp0_valid),
    .rsp1_valid (bus.rsp1_valid)
  );

endmodule

// File: tb/tb_alu_arbiter_2req.sv
// Scoreboard bench for alu_arbiter_2req: a cycle model predicts readies,
// response valids, busy and the counter; expected results are queued per
// requester at acceptance and compared while the response is presented.
module tb_alu_arbiter_2req;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  always #5 clk = ~clk;

  alu_arbiter_2req_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter_2req #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .done_count (done_count)
  );

  // External ALU stand-in: subtract built as a + ~b + 1.
  always_comb begin
    case (bus.alu_c)
      2'b00:   bus.alu_y = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_y = bus.alu_a + ~bus.alu_b + 32'd1;
      2'b10:   bus.alu_y = bus.alu_a & bus.alu_b;
      default: bus.alu_y = bus.alu_a ^ bus.alu_b;
    endcase
  end

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // cycle model state
  int               m_state = 0;
  logic             m_owner = 1'b0;
  logic             m_last  = 1'b1;
  logic [CNT_W-1:0] m_cnt   = '0;
  logic [31:0]      q0[$];
  logic [31:0]      q1[$];
  logic [1:0]       acc_pulse = 2'b00;
  int               cyc = 0;
  int               acc_cyc[$];
  int               acc_who[$];

  // Model: check at negedge, advance at posedge.
  always begin : mon
    logic g, e0, e1, r0, r1, h;
    @(negedge clk);
    e0 = 1'b0; e1 = 1'b0; h = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) g = ~m_last;
      else g = bus.req1_valid;
      e0 = (m_state == 0) && !g && bus.req0_valid;
      e1 = (m_state == 0) &&  g && bus.req1_valid;
      r0 = (m_state == 2) && !m_owner;
      r1 = (m_state == 2) &&  m_owner;
      check("req0_ready", 32'(bus.req0_ready), 32'(e0));
      check("req1_ready", 32'(bus.req1_ready), 32'(e1));
      check("rsp0_valid", 32'(bus.rsp0_valid), 32'(r0));
      check("rsp1_valid", 32'(bus.rsp1_valid), 32'(r1));
      check("busy", 32'(busy), 32'(m_state != 0));
      check("done_count", 32'(done_count), 32'(m_cnt));
      if (e0) q0.push_back(ref_op(bus.req0_op, bus.req0_a, bus.req0_b));
      if (e1) q1.push_back(ref_op(bus.req1_op, bus.req1_a, bus.req1_b));
      if (r0) begin
        if (q0.size() == 0) check("rsp0_queue", 32'd0, 32'd1);
        else begin
          check("rsp0_data", bus.rsp0_data, q0[0]);
          if (bus.rsp0_ready) void'(q0.pop_front());
        end
        h = bus.rsp0_ready;
      end
      if (r1) begin
        if (q1.size() == 0) check("rsp1_queue", 32'd0, 32'd1);
        else begin
          check("rsp1_data", bus.rsp1_data, q1[0]);
          if (bus.rsp1_ready) void'(q1.pop_front());
        end
        h = bus.rsp1_ready;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_state = 0; m_owner = 1'b0; m_last = 1'b1; m_cnt = '0;
      q0.delete(); q1.delete(); acc_pulse = 2'b00;
    end else begin
      acc_pulse = {e1, e0};
      case (m_state)
        0: if (e0 || e1) begin
             m_state = 1; m_owner = e1; m_last = e1;
             acc_cyc.push_back(cyc); acc_who.push_back(int'(e1));
           end
        1: m_state = 2;
        default: if (h) begin m_state = 0; m_cnt = m_cnt + 1'b1; end
      endcase
    end
  end

  task automatic issue(input int n, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int k;
    if (n == 0) begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!acc_pulse[n] && k < 200);
    if (!acc_pulse[n]) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop(input int n);
    if (n == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while ((m_state != 0 || q0.size() != 0 || q1.size() != 0) && k < 200);
    if (k >= 200) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_alu_c", 32'(bus.alu_c), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("rst_rsp0_data", bus.rsp0_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(done_count), 32'd0);

    // 1: add wraps to zero, three-cycle turnaround
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    drop(0);
    wait_idle();
    check("t1_count", 32'(done_count), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: simultaneous requests after reset, requester 0 first
    do_reset();
    base = acc_who.size();
    fork
      begin issue(0, 2'b01, 32'd5, 32'd7); drop(0); end
      begin issue(1, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00); drop(1); end
    join
    wait_idle();
    check("t2_first", 32'(acc_who[base]), 32'd0);
    check("t2_second", 32'(acc_who[base+1]), 32'd1);
    check("t2_count", 32'(done_count), 32'd2);

    // 3: both requesters saturating, strict alternation every 3 cycles
    do_reset();
    base = acc_who.size();
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 2'($urandom_range(3)), $urandom, $urandom);
        drop(0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 2'($urandom_range(3)), $urandom, $urandom);
        drop(1);
      end
    join
    wait_idle();
    for (int i = 0; i < 8; i++) check("t3_order", 32'(acc_who[base+i]), 32'(i % 2));
    for (int i = 1; i < 8; i++)
      check("t3_spacing", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'd3);
    check("t3_count", 32'(done_count), 32'd8);

    // 4: back-pressured xor result held stable, competing request blocked
    bus.rsp1_ready = 1'b0;
    issue(1, 2'b11, 32'h1234_5678, 32'hFFFF_FFFF);
    drop(1);
    bus.req0_op = 2'b00; bus.req0_a = 32'd10; bus.req0_b = 32'd20; bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_valid", 32'(bus.rsp1_valid), 32'd1);
      check("t4_data", bus.rsp1_data, 32'hEDCB_A987);
      check("t4_ready0", 32'(bus.req0_ready), 32'd0);
      check("t4_ready1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_count", 32'(done_count), 32'd9);
    check("t4_rsp1_done", 32'(bus.rsp1_valid), 32'd0);
    issue(0, 2'b00, 32'd10, 32'd20);
    drop(0);
    wait_idle();

    // 5: reset during EXEC discards the operation
    do_reset();
    issue(0, 2'b00, 32'd3, 32'd4);
    drop(0);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("t5_count", 32'(done_count), 32'd0);
    check("t5_alu_a", bus.alu_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("t5_no_rsp", 32'(bus.rsp0_valid), 32'd0);
    end
    issue(0, 2'b00, 32'd3, 32'd4);
    drop(0);
    wait_idle();
    check("t5_fresh_count", 32'(done_count), 32'd1);

    // 6: counter wraps on the 16th completion
    for (int i = 0; i < 15; i++) begin
      issue(i % 2, 2'($urandom_range(3)), $urandom, $urandom);
      drop(i % 2);
      wait_idle();
      if (i == 13) check("t6_pre_wrap", 32'(done_count), 32'd15);
    end
    check("t6_wrap", 32'(done_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter_2req.md
Name: alu_arbiter_2req

Overview:
- Shares one 32-bit 4-op ALU (add/sub/and/xor, 2-bit op select) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block registers the ALU operands, captures the ALU result, and returns it to the granting requester.
- Fair round-robin arbitration. Sits between the ALU and its two client blocks.

Parameters:
WIDTH, 32, operand/result width; must equal the ALU width.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 request accepted this cycle when valid also high
req0_op  in  2  00 add, 01 sub (a-b), 10 and, 11 xor
req0_a  in  WIDTH  operand a
req0_b  in  WIDTH  operand b
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  WIDTH  result
rsp1_valid, rsp1_ready, rsp1_data  same as requester 0
alu_c  out  2  op select to ALU
alu_a  out  WIDTH  operand a to ALU
alu_b  out  WIDTH  operand b to ALU
alu_y  in  WIDTH  ALU result (combinational from alu_c/alu_a/alu_b)
busy  out  1  state != IDLE
done_count  out  CNT_W  total completed responses

Behaviour:
- Reset (async, rst high), all registered:
  - state=IDLE; alu_c=00; alu_a=0; alu_b=0; result=0; owner=0.
  - last_grant=1, so requester 0 wins the first tie.
  - done_count=0; rsp0_valid=rsp1_valid=0.
- States:
  - IDLE: grant selection.
  - EXEC: ALU inputs stable from registers.
  - RESP: result held until the owner's rsp_ready.
- Grant (combinational, IDLE only):
  - Only req0_valid: grant=0. Only req1_valid: grant=1.
  - Both valid: grant = ~last_grant.
  - reqN_ready = (state==IDLE) && (grant==N) && reqN_valid.
  - Both readys are 0 outside IDLE.
  - A ready never asserts for a non-valid requester.
  - At most one ready per cycle.
- Handshake at cycle T (reqN_valid && reqN_ready):
  - Latch op->alu_c, a->alu_a, b->alu_b, owner=N, last_grant=N.
  - Next state EXEC.
- EXEC (cycle T+1):
  - Capture alu_y into result at the end of the cycle. Next state RESP.
- RESP (from T+2):
  - rsp<owner>_valid=1 and rsp<owner>_data=result; the other rsp valid is 0.
  - Data is held stable while valid && !ready.
  - On rsp<owner>_ready=1: done_count increments (wraps at 2^CNT_W-1 -> 0), next state IDLE.
  - The earliest next accept is the cycle after the response handshake.
  - Minimum 3 cycles per operation for both requesters combined.
- rspN_data is only meaningful while rspN_valid. It drives the result register, or 0 when not owner.
- Arithmetic: modulo 2^WIDTH, no carry/overflow outputs.
  - Subtract is two's complement, a + ~b + 1.
- Request inputs may change freely while not handshaked. After acceptance, they are ignored until the next grant.
- rsp_ready for the non-owner is ignored. rsp_ready outside RESP is ignored.
- A requester holding valid through RESP retains priority per round-robin. Requests are never dropped or duplicated.
- Reset mid-operation (EXEC or RESP):
  - The in-flight operation is discarded; no response is issued.
  - All registers return to reset values immediately.
- alu_c/alu_a/alu_b hold their last values in IDLE (no toggling).

Test Plan:
1. After reset, req0 add a=0xFFFFFFFF b=0x00000001: req0_ready=1 at T; rsp0_valid=1 from T+2 with rsp0_data=0x00000000; with rsp0_ready=1, done_count=1 and busy=0 at T+3.
2. After reset, req0 sub a=5 b=7 and req1 and a=0xF0F0F0F0 b=0xFF00FF00, both valid the same cycle: requester 0 is served first with 0xFFFFFFFE, then requester 1 with 0xF000F000; rsp1_valid stays 0 during requester 0's response.
3. Both valid continuously, four ops each, rsp_ready tied high: grant order 0,1,0,1,...; each accept is 3 cycles apart; done_count=8 at the end.
4. req1 xor a=0x12345678 b=0xFFFFFFFF with rsp1_ready low for 5 cycles: rsp1_valid=1 and data=0xEDCBA987 stable throughout; req0_ready=0 and req1_ready=0 the whole time; completes on the first ready-high cycle.
5. Assert rst during EXEC of req0 add 3+4: next cycle state=IDLE, no rsp0_valid ever; done_count=0; a fresh request completes normally afterwards.
6. done_count preloaded near wrap via 65536 completions, or CNT_W=4 with 16 ops: counter wraps to 0 on the last response.
